ex_mem_stage: RTL and testbench

- Pipeline register between EX and MEM, plus the MEM stage logic, for the 5-stage MIPS core (subset: addu, subu, ori, lui, addi, lw, sw, beq, j, jal, jr, jalr).
- Latches the EX results and owns the 1024-word data memory.
- Forwards WB data into the store path.
- Produces the instruction, PC and write-back value that the MEM/WB register captures. Also exports the M-stage forwarding source for EX.

---
 rtl/ex_mem_stage_pkg.sv | 30 +++
 rtl/ctrl.sv | 54 +++++
 rtl/ex_mem_stage_dm.sv | 41 ++++
 rtl/ex_mem_stage.sv | 121 ++++++++++++
 tb/tb_ex_mem_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline slice of the 5-stage MIPS core.
// Holds the opcode and funct encodings of the supported instruction subset
// and the RegDst encoding used to pick the destination register.
package ex_mem_stage_pkg;

   // Primary opcodes (I[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   // R-type funct codes (I[5:0])
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // Destination register select
   typedef enum logic [1:0] {
      REGDST_RT = 2'd0,
      REGDST_RD = 2'd1,
      REGDST_RA = 2'd2
   } regdst_e;

endpackage

// File: rtl/ctrl.sv
// Shared instruction decoder.
// Ports:
//   op, fn      : opcode I[31:26] and funct I[5:0]
//   reg_write   : instruction writes the register file
//   reg_dst     : which field names the destination (rt, rd or $31)
//   mem_write   : instruction is a store
//   mem_to_reg  : write-back value comes from data memory (load)
//   link        : write-back value is the return address PC+8
// Anything outside the supported subset, including sll $0 (all-zero word),
// decodes with every control inactive.
module ctrl
   import ex_mem_stage_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] fn,
   output logic       reg_write,
   output regdst_e    reg_dst,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       link
);

   always_comb begin
      reg_write  = 1'b0;
      reg_dst    = REGDST_RT;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      link       = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            reg_dst = REGDST_RD;
            if (fn == FN_ADDU || fn == FN_SUBU) begin
               reg_write = 1'b1;
            end else if (fn == FN_JALR) begin
               reg_write = 1'b1;
               link      = 1'b1;
            end
         end
         OP_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         OP_SW:                   mem_write = 1'b1;
         OP_ORI, OP_LUI, OP_ADDI: reg_write = 1'b1;
         OP_JAL: begin
            reg_write = 1'b1;
            reg_dst   = REGDST_RA;
            link      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage_dm.sv
// Word-addressed data memory for the MEM stage.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears every word)
//   we         : write strobe, sampled on the rising clock edge
//   addr       : word address
//   wdata      : word to store
//   pc         : PC of the storing instruction, for the write trace
//   full_addr  : word-aligned byte address, for the write trace
//   rdata      : asynchronous read of the addressed word
module ex_mem_stage_dm #(
   parameter int DM_WORDS = 1024,
   parameter int DM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [DM_AW-1:0] addr,
   input  logic [31:0]      wdata,
   input  logic [31:0]      pc,
   input  logic [31:0]      full_addr,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DM_WORDS];

   // Reset has priority over a store on the same edge, so a store that
   // collides with reset neither lands nor shows up in the trace.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DM_WORDS; k++) begin
            mem_q[k] <= '0;
         end
      end else if (we) begin
         mem_q[addr] <= wdata;
         $display("@%h: *%h <= %h", pc, full_addr, wdata);
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus MEM-stage logic.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   nI, nPC, nALU, nRT  : instruction, PC, ALU result and rt operand from EX
//   wb_WD, wb_A3, wb_we : register write currently happening in WB
//   I, PC               : latched instruction and PC for MEM/WB
//   WD                  : write-back value for MEM/WB
//   A3                  : destination register in M (0 when not writing)
//   fwd_valid           : WD is final and may be forwarded to EX
//   dm_rdata            : raw data memory read word
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DM_WORDS = 1024,
   parameter int DM_AW    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] nI,
   input  logic [31:0] nPC,
   input  logic [31:0] nALU,
   input  logic [31:0] nRT,
   input  logic [31:0] wb_WD,
   input  logic [4:0]  wb_A3,
   input  logic        wb_we,
   output logic [31:0] I,
   output logic [31:0] PC,
   output logic [31:0] WD,
   output logic [4:0]  A3,
   output logic        fwd_valid,
   output logic [31:0] dm_rdata
);

   logic [31:0] i_q, i_d, pc_q, pc_d, alu_q, alu_d, rt_q, rt_d;
   logic        reg_write, mem_write, mem_to_reg, link;
   regdst_e     reg_dst;
   logic [31:0] store_data;
   logic        unused_fields;

   // Next-state for the pipeline registers: reset clears, otherwise load EX.
   always_comb begin
      i_d   = nI;
      pc_d  = nPC;
      alu_d = nALU;
      rt_d  = nRT;
      if (reset) begin
         i_d   = '0;
         pc_d  = '0;
         alu_d = '0;
         rt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      i_q   <= i_d;
      pc_q  <= pc_d;
      alu_q <= alu_d;
      rt_q  <= rt_d;
   end

   ctrl u_ctrl (
      .op         (i_q[31:26]),
      .fn         (i_q[5:0]),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .link       (link)
   );

   // The instruction in WB may be writing the very register this store reads;
   // its value was not yet visible when EX forwarded rt, so bypass it here.
   always_comb begin
      store_data = rt_q;
      if (wb_we && wb_A3 == i_q[20:16] && wb_A3 != 5'd0) begin
         store_data = wb_WD;
      end
   end

   ex_mem_stage_dm #(
      .DM_WORDS (DM_WORDS),
      .DM_AW    (DM_AW)
   ) u_dm (
      .clk       (clk),
      .reset     (reset),
      .we        (mem_write && !reset),
      .addr      (alu_q[DM_AW+1:2]),
      .wdata     (store_data),
      .pc        (pc_q),
      .full_addr ({alu_q[31:2], 2'b00}),
      .rdata     (dm_rdata)
   );

   // Destination register and write-back value selection.
   always_comb begin
      A3 = 5'd0;
      if (reg_write) begin
         unique case (reg_dst)
            REGDST_RD: A3 = i_q[15:11];
            REGDST_RA: A3 = 5'd31;
            default:   A3 = i_q[20:16];
         endcase
      end
      if (mem_to_reg) begin
         WD = dm_rdata;
      end else if (link) begin
         WD = pc_q + 32'd8;
      end else begin
         WD = alu_q;
      end
   end

   // A load's data only becomes final in WB; the hazard unit stalls on it.
   assign fwd_valid = (A3 != 5'd0) && !mem_to_reg;

   assign I  = i_q;
   assign PC = pc_q;

   assign unused_fields = ^{i_q[25:21], i_q[10:6]};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] nI, nPC, nALU, nRT, wb_WD;
   logic [4:0]  wb_A3;
   logic        wb_we;
   logic [31:0] I, PC, WD, dm_rdata;
   logic [4:0]  A3;
   logic        fwd_valid;

   int checkCount = 0;
   int failCount  = 0;

   ex_mem_stage dut (
      .clk       (clk),
      .reset     (reset),
      .nI        (nI),
      .nPC       (nPC),
      .nALU      (nALU),
      .nRT       (nRT),
      .wb_WD     (wb_WD),
      .wb_A3     (wb_A3),
      .wb_we     (wb_we),
      .I         (I),
      .PC        (PC),
      .WD        (WD),
      .A3        (A3),
      .fwd_valid (fwd_valid),
      .dm_rdata  (dm_rdata)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   // Present one instruction to EX outputs and let it latch into M
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] rt);
      nI   = instr;
      nPC  = pc;
      nALU = alu;
      nRT  = rt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Load the word at the given byte address and expect a value in WD
   task automatic loadAndCheck(input string tag, input logic [31:0] addr,
                               input logic [31:0] expected);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h0), 32'h0000_3100, addr, 32'h0);
      checkOutput(tag, WD, expected);
   endtask

   initial begin
      reset = 1'b1;
      nI = '0; nPC = '0; nALU = '0; nRT = '0;
      wb_WD = '0; wb_A3 = '0; wb_we = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst_I",   I, 32'h0);
      checkOutput("rst_PC",  PC, 32'h0);
      checkOutput("rst_WD",  WD, 32'h0);
      checkOutput("rst_A3",  {27'h0, A3}, 32'h0);
      checkOutput("rst_fwd", {31'h0, fwd_valid}, 32'h0);
      checkOutput("rst_dm",  dm_rdata, 32'h0);

      $display("[TB] basic store then load");
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h10), 32'h0000_3000, 32'h10, 32'h1234_5678);
      checkOutput("sw_A3",  {27'h0, A3}, 32'h0);
      checkOutput("sw_fwd", {31'h0, fwd_valid}, 32'h0);
      checkOutput("sw_PC",  PC, 32'h0000_3000);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h10), 32'h0000_3004, 32'h10, 32'h0);
      checkOutput("lw_WD",  WD, 32'h1234_5678);
      checkOutput("lw_A3",  {27'h0, A3}, 32'd6);
      checkOutput("lw_fwd", {31'h0, fwd_valid}, 32'h0);

      $display("[TB] WB bypass into store data");
      wb_we = 1'b1; wb_A3 = 5'd5; wb_WD = 32'hBEEF_0001;
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h40), 32'h0000_3008, 32'h40, 32'hAAAA_AAAA);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h40), 32'h0000_300C, 32'h40, 32'h0);
      checkOutput("byp_hit", WD, 32'hBEEF_0001);
      wb_A3 = 5'd0;
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h44), 32'h0000_3010, 32'h44, 32'hAAAA_AAAA);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h44), 32'h0000_3014, 32'h44, 32'h0);
      checkOutput("byp_zero", WD, 32'hAAAA_AAAA);
      wb_A3 = 5'd7;
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h48), 32'h0000_3018, 32'h48, 32'h5555_0000);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h48), 32'h0000_301C, 32'h48, 32'h0);
      checkOutput("byp_other", WD, 32'h5555_0000);
      wb_A3 = 5'd5; wb_we = 1'b0;
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h4C), 32'h0000_3020, 32'h4C, 32'h7777_0000);
      applyStimulus(mkI(6'h23, 5'd0, 5'd6, 16'h4C), 32'h0000_3024, 32'h4C, 32'h0);
      checkOutput("byp_nowe", WD, 32'h7777_0000);
      wb_A3 = 5'd0; wb_WD = 32'h0;

      $display("[TB] link and ALU write-back");
      applyStimulus(32'h0C00_0000, 32'h0000_3004, 32'h0, 32'h0);
      checkOutput("jal_WD",  WD, 32'h0000_300C);
      checkOutput("jal_A3",  {27'h0, A3}, 32'd31);
      checkOutput("jal_fwd", {31'h0, fwd_valid}, 32'h1);
      applyStimulus(mkR(5'd1, 5'd2, 5'd3, 6'h21), 32'h0000_3008, 32'd7, 32'h0);
      checkOutput("addu_WD", WD, 32'd7);
      checkOutput("addu_A3", {27'h0, A3}, 32'd3);
      checkOutput("addu_fwd", {31'h0, fwd_valid}, 32'h1);
      applyStimulus(mkR(5'd1, 5'd0, 5'd4, 6'h09), 32'hFFFF_FFFC, 32'h0, 32'h0);
      checkOutput("jalr_WD", WD, 32'h0000_0004);
      checkOutput("jalr_A3", {27'h0, A3}, 32'd4);
      applyStimulus(mkR(5'd1, 5'd0, 5'd0, 6'h08), 32'h0000_3010, 32'h0, 32'h0);
      checkOutput("jr_A3",  {27'h0, A3}, 32'h0);
      checkOutput("jr_fwd", {31'h0, fwd_valid}, 32'h0);
      applyStimulus(mkI(6'h0d, 5'd0, 5'd7, 16'h5), 32'h0000_3014, 32'h0000_0005, 32'h0);
      checkOutput("ori_A3", {27'h0, A3}, 32'd7);
      checkOutput("ori_WD", WD, 32'h5);
      applyStimulus(mkI(6'h04, 5'd1, 5'd2, 16'h3), 32'h0000_3018, 32'h0, 32'h0);
      checkOutput("beq_A3", {27'h0, A3}, 32'h0);

      $display("[TB] store colliding with reset");
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h20), 32'h0000_3020, 32'h20, 32'h5555_5555);
      reset = 1'b1;
      applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      reset = 1'b0;
      checkOutput("rst2_I",   I, 32'h0);
      checkOutput("rst2_PC",  PC, 32'h0);
      checkOutput("rst2_WD",  WD, 32'h0);
      checkOutput("rst2_A3",  {27'h0, A3}, 32'h0);
      checkOutput("rst2_fwd", {31'h0, fwd_valid}, 32'h0);
      loadAndCheck("rst2_lw20", 32'h20, 32'h0);
      loadAndCheck("rst2_lw10", 32'h10, 32'h0);

      $display("[TB] address aliasing");
      applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h0), 32'h0000_3030, 32'h0000_1004, 32'hCAFE_0001);
      loadAndCheck("alias_lw4", 32'h0000_0006, 32'hCAFE_0001);
      checkOutput("alias_rd", dm_rdata, 32'hCAFE_0001);

      $display("[TB] back-to-back stores then loads");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(mkI(6'h2b, 5'd0, 5'd5, 16'h0), 32'h0000_3040 + 32'(k * 4),
                       32'(k * 4), 32'h0000_0100 + 32'(k));
      end
      for (int k = 0; k < 4; k++) begin
         loadAndCheck($sformatf("b2b_lw%0d", k), 32'(k * 4), 32'h0000_0100 + 32'(k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
